// File: rtl/demo_sequencer.sv
// -----------------------------------------------------------------------------
// demo_sequencer
//   Timeline master for the VGA demo. Counts whole frames and half-frames from
//   the hvsync timing pulses and derives the control set consumed by the
//   pixel/colour generator: frame counter, timer, part index, in-part frame,
//   beat flag and decay envelope. Operator pause / single-step / skip-part
//   requests are only applied on frame_start, so the timeline never changes
//   in the middle of a frame.
//
// Parameters
//   FC_W       frame counter width (timer is FC_W+1 bits)
//   PART_LSB   part = frame_counter[PART_LSB+2:PART_LSB]
//   HALF_LINE  line on which the hvsync generator raises half_frame (x==0)
//
// Ports
//   clk            in   pixel clock
//   rst_n          in   synchronous active-low reset
//   frame_start    in   1-cycle pulse at x==0, y==0
//   half_frame     in   1-cycle pulse at x==0, y==HALF_LINE
//   pause          in   level, 1 = freeze timeline
//   step           in   pulse, while paused advance exactly one frame
//   skip           in   pulse, jump to frame 0 of the next part
//   frame_counter  out  whole-frame count
//   frame_frac     out  half-frame bit
//   timer          out  {frame_counter, frame_frac}
//   part           out  frame_counter[PART_LSB+2:PART_LSB]
//   part_frame     out  frame_counter[PART_LSB-1:0]
//   beat_1_3       out  timer[5:4] == 2'b10
//   envelope_b     out  31 - 2*timer[3:0] (mod 32)
//   part_start     out  1-cycle pulse when part_frame becomes 0
//   loop_wrap      out  1-cycle pulse when frame_counter[PART_LSB+2:0] wraps to 0
// -----------------------------------------------------------------------------
module demo_sequencer #(
   parameter int unsigned FC_W      = 12,
   parameter int unsigned PART_LSB  = 7,
   parameter int unsigned HALF_LINE = 262
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_start,
   input  logic                half_frame,
   input  logic                pause,
   input  logic                step,
   input  logic                skip,
   output logic [FC_W-1:0]     frame_counter,
   output logic                frame_frac,
   output logic [FC_W:0]       timer,
   output logic [2:0]          part,
   output logic [PART_LSB-1:0] part_frame,
   output logic                beat_1_3,
   output logic [4:0]          envelope_b,
   output logic                part_start,
   output logic                loop_wrap
);

   localparam int unsigned HI_W = FC_W - PART_LSB;
   localparam logic [HI_W-1:0] HI_ONE = HI_W'(1);
   localparam logic [FC_W-1:0] FC_ONE = FC_W'(1);

   // Elaboration-time sanity check on the geometry.
   if (PART_LSB + 3 > FC_W || FC_W < 5 || HALF_LINE == 0) begin : g_bad_params
      $error("demo_sequencer: inconsistent FC_W/PART_LSB/HALF_LINE");
   end

   typedef enum logic {
      RUN    = 1'b0,
      PAUSED = 1'b1
   } state_t;

   state_t          state_q, state_n;
   logic [FC_W-1:0] fc_q, fc_n;
   logic            frac_q, frac_n;
   logic            skip_pend_q, skip_pend_n;
   logic            step_pend_q, step_pend_n;
   logic            skip_eff, step_eff;
   logic            advance;
   logic [FC_W:0]   timer_n;
   logic            beat_q;
   logic [4:0]      env_q;
   logic            part_start_q, loop_wrap_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= RUN;
         fc_q         <= '0;
         frac_q       <= 1'b0;
         skip_pend_q  <= 1'b0;
         step_pend_q  <= 1'b0;
         beat_q       <= 1'b0;
         env_q        <= '1;
         part_start_q <= 1'b0;
         loop_wrap_q  <= 1'b0;
      end else begin
         state_q      <= state_n;
         fc_q         <= fc_n;
         frac_q       <= frac_n;
         skip_pend_q  <= skip_pend_n;
         step_pend_q  <= step_pend_n;
         beat_q       <= (timer_n[5:4] == 2'b10);
         env_q        <= 5'd31 - {timer_n[3:0], 1'b0};
         part_start_q <= advance && (fc_n[PART_LSB-1:0] == '0);
         loop_wrap_q  <= advance && (fc_n[PART_LSB+2:0] == '0);
      end
   end

   always_comb begin
      state_n = state_q;
      if (pause) state_n = PAUSED;
      else       state_n = RUN;
   end

   // A request arriving in the same cycle as frame_start is honoured
   // immediately; a step seen while running is simply dropped.
   always_comb begin
      skip_eff    = skip_pend_q | skip;
      step_eff    = step_pend_q | (step && (state_q == PAUSED));
      skip_pend_n = skip_eff;
      step_pend_n = step_eff;
      fc_n        = fc_q;
      frac_n      = frac_q;
      advance     = 1'b0;
      if (frame_start) begin
         skip_pend_n = 1'b0;
         step_pend_n = 1'b0;
         if (skip_eff) begin
            fc_n    = {fc_q[FC_W-1:PART_LSB] + HI_ONE, {PART_LSB{1'b0}}};
            frac_n  = 1'b0;
            advance = 1'b1;
         end else if ((state_q == RUN) || step_eff) begin
            fc_n    = fc_q + FC_ONE;
            frac_n  = 1'b0;
            advance = 1'b1;
         end
      end else if (half_frame && (state_q == RUN)) begin
         frac_n = 1'b1;
      end
      timer_n = {fc_n, frac_n};
   end

   assign frame_counter = fc_q;
   assign frame_frac    = frac_q;
   assign timer         = {fc_q, frac_q};
   assign part          = fc_q[PART_LSB+2:PART_LSB];
   assign part_frame    = fc_q[PART_LSB-1:0];
   assign beat_1_3      = beat_q;
   assign envelope_b    = env_q;
   assign part_start    = part_start_q;
   assign loop_wrap     = loop_wrap_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// -----------------------------------------------------------------------------
// tb_demo_sequencer
//   Directed bench for demo_sequencer: reset values, frame/half-frame counting,
//   part and loop boundaries, pause/step, skip, reset with pending requests and
//   a full 0..63 timer sweep of beat_1_3 / envelope_b.
// -----------------------------------------------------------------------------
module tb_demo_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start, half_frame, pause, step, skip;
   logic [11:0] frame_counter;
   logic        frame_frac;
   logic [12:0] timer;
   logic [2:0]  part;
   logic [6:0]  part_frame;
   logic        beat_1_3;
   logic [4:0]  envelope_b;
   logic        part_start, loop_wrap;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   demo_sequencer #(.FC_W(12), .PART_LSB(7), .HALF_LINE(262)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_start  (frame_start),
      .half_frame   (half_frame),
      .pause        (pause),
      .step         (step),
      .skip         (skip),
      .frame_counter(frame_counter),
      .frame_frac   (frame_frac),
      .timer        (timer),
      .part         (part),
      .part_frame   (part_frame),
      .beat_1_3     (beat_1_3),
      .envelope_b   (envelope_b),
      .part_start   (part_start),
      .loop_wrap    (loop_wrap)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic fs();
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
   endtask

   task automatic hf();
      @(negedge clk) half_frame = 1'b1;
      @(negedge clk) half_frame = 1'b0;
   endtask

   task automatic pulse_skip();
      @(negedge clk) skip = 1'b1;
      @(negedge clk) skip = 1'b0;
   endtask

   task automatic pulse_step();
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
   endtask

   task automatic frames(input int unsigned n);
      repeat (n) begin
         fs();
         idle(1);
      end
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [4:0] e;
      rst_n = 1'b0; frame_start = 1'b0; half_frame = 1'b0;
      pause = 1'b0; step = 1'b0; skip = 1'b0;
      idle(3);
      rst_n = 1'b1;

      // reset state
      check("rst_fc",    32'(frame_counter), 32'd0);
      check("rst_frac",  32'(frame_frac),    32'd0);
      check("rst_timer", 32'(timer),         32'd0);
      check("rst_env",   32'(envelope_b),    32'd31);
      check("rst_beat",  32'(beat_1_3),      32'd0);
      check("rst_pstart",32'(part_start),    32'd0);
      check("rst_lwrap", 32'(loop_wrap),     32'd0);

      // 1: three frames, each with a half-frame
      repeat (3) begin
         fs(); idle(1); hf(); idle(1);
      end
      check("t1_fc",    32'(frame_counter), 32'd3);
      check("t1_frac",  32'(frame_frac),    32'd1);
      check("t1_timer", 32'(timer),         32'd7);
      check("t1_env",   32'(envelope_b),    32'd17);

      // 2: part boundary at 128, loop wrap at 1024
      frames(124);
      check("t2_fc127", 32'(frame_counter), 32'd127);
      check("t2_pf127", 32'(part_frame),    32'd127);
      fs();
      check("t2_fc128",   32'(frame_counter), 32'd128);
      check("t2_part1",   32'(part),          32'd1);
      check("t2_pf0",     32'(part_frame),    32'd0);
      check("t2_pstart",  32'(part_start),    32'd1);
      check("t2_nolwrap", 32'(loop_wrap),     32'd0);
      idle(1);
      check("t2_pstart_off", 32'(part_start), 32'd0);
      frames(895);
      check("t2_fc1023", 32'(frame_counter), 32'd1023);
      check("t2_part7",  32'(part),          32'd7);
      fs();
      check("t2_fc1024", 32'(frame_counter), 32'd1024);
      check("t2_lwrap",  32'(loop_wrap),     32'd1);
      check("t2_part0",  32'(part),          32'd0);
      check("t2_pstart2",32'(part_start),    32'd1);
      idle(1);
      check("t2_lwrap_off", 32'(loop_wrap), 32'd0);

      // 3: pause, step, step while running
      pause = 1'b1;
      idle(2);
      repeat (5) fs();
      check("t3_hold", 32'(frame_counter), 32'd1024);
      hf();
      check("t3_frac_hold", 32'(frame_frac), 32'd0);
      pulse_step();
      idle(1);
      check("t3_step_wait", 32'(frame_counter), 32'd1024);
      fs();
      check("t3_step_apply", 32'(frame_counter), 32'd1025);
      fs();
      check("t3_step_once", 32'(frame_counter), 32'd1025);
      pause = 1'b0;
      idle(2);
      pulse_step();
      idle(1);
      fs();
      check("t3_run_step_drop", 32'(frame_counter), 32'd1026);

      // 4: skip from part 1 at fc=200, then skip at fc=1000
      do_reset();
      frames(200);
      check("t4_fc200", 32'(frame_counter), 32'd200);
      check("t4_part1", 32'(part),          32'd1);
      check("t4_pf72",  32'(part_frame),    32'd72);
      hf();
      pulse_skip();
      idle(2);
      check("t4_skip_wait", 32'(frame_counter), 32'd200);
      check("t4_frac_pre",  32'(frame_frac),    32'd1);
      fs();
      check("t4_fc256",   32'(frame_counter), 32'd256);
      check("t4_part2",   32'(part),          32'd2);
      check("t4_frac0",   32'(frame_frac),    32'd0);
      check("t4_pstart",  32'(part_start),    32'd1);
      check("t4_nolwrap", 32'(loop_wrap),     32'd0);
      frames(744);
      check("t4_fc1000", 32'(frame_counter), 32'd1000);
      pulse_skip();
      idle(1);
      fs();
      check("t4_fc1024", 32'(frame_counter), 32'd1024);
      check("t4_lwrap",  32'(loop_wrap),     32'd1);

      // 5: skip+step together while paused, then reset with pending skip
      pause = 1'b1;
      idle(2);
      @(negedge clk) begin skip = 1'b1; step = 1'b1; end
      @(negedge clk) begin skip = 1'b0; step = 1'b0; end
      idle(1);
      fs();
      check("t5_jump",   32'(frame_counter), 32'd1152);
      check("t5_part1",  32'(part),          32'd1);
      check("t5_pstart", 32'(part_start),    32'd1);
      fs();
      check("t5_still_paused", 32'(frame_counter), 32'd1152);
      pulse_skip();
      idle(1);
      pause = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      check("t5_rst_fc",  32'(frame_counter), 32'd0);
      check("t5_rst_env", 32'(envelope_b),    32'd31);
      check("t5_rst_tmr", 32'(timer),         32'd0);
      fs();
      check("t5_no_jump", 32'(frame_counter), 32'd1);
      check("t5_pf1",     32'(part_frame),    32'd1);

      // 6: timer sweep 0..63
      do_reset();
      for (int t = 0; t < 64; t++) begin
         e = 5'(31 - 2 * (t % 16));
         check("t6_timer", 32'(timer),      32'(t));
         check("t6_beat",  32'(beat_1_3),   (t >= 32 && t < 48) ? 32'd1 : 32'd0);
         check("t6_env",   32'(envelope_b), 32'(e));
         if (t % 2 == 0) hf();
         else            fs();
      end
      check("t6_fc32", 32'(frame_counter), 32'd32);

      // frame_start and half_frame together: frame_start wins
      @(negedge clk) begin frame_start = 1'b1; half_frame = 1'b1; end
      @(negedge clk) begin frame_start = 1'b0; half_frame = 1'b0; end
      check("coinc_fc",   32'(frame_counter), 32'd33);
      check("coinc_frac", 32'(frame_frac),    32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
